// File: rtl/kbd_view_encoder_pkg.sv
// Shared definitions for the keyboard -> text-view encoder.
//   - character codes understood by the VGA text view (code_null .. code_end),
//     plus code_none, used internally to mean "key has no mapping"
//   - cmd[] bit positions
//   - PS/2 scan-code set 2 constants
//   - decoder / receiver state enums and the make-code -> character mapping
package view_codes_pkg;

  localparam logic [5:0] code_null    = 6'd0;
  localparam logic [5:0] code_a       = 6'd1;   // a..z    -> 1..26
  localparam logic [5:0] code_cap_a   = 6'd27;  // A..Z    -> 27..52
  localparam logic [5:0] code_dollar  = 6'd53;
  localparam logic [5:0] code_lparen  = 6'd54;
  localparam logic [5:0] code_rparen  = 6'd55;
  localparam logic [5:0] code_equal   = 6'd56;
  localparam logic [5:0] code_starter = 6'd57;
  localparam logic [5:0] code_lambda  = 6'd58;
  localparam logic [5:0] code_space   = 6'd59;
  localparam logic [5:0] code_dot     = 6'd60;
  localparam logic [5:0] code_end     = 6'd61;
  localparam logic [5:0] code_none    = 6'd63;

  localparam int CMD_BUSY  = 0;
  localparam int CMD_PGUP  = 1;
  localparam int CMD_PGDN  = 2;
  localparam int CMD_BKSP  = 3;
  localparam int CMD_BREAK = 4;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_PGUP   = 8'h7D;
  localparam logic [7:0] SC_PGDN   = 8'h7A;
  localparam logic [7:0] SC_4      = 8'h25;
  localparam logic [7:0] SC_9      = 8'h46;
  localparam logic [7:0] SC_0      = 8'h45;
  localparam logic [7:0] SC_EQUAL  = 8'h55;
  localparam logic [7:0] SC_GRAVE  = 8'h0E;
  localparam logic [7:0] SC_BSLASH = 8'h5D;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_DOT    = 8'h49;
  localparam logic [7:0] SC_ESC    = 8'h76;

  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Alphabet position (1..26) of a letter make code, 0 if not a letter.
  function automatic logic [4:0] letter_index(input logic [7:0] sc);
    case (sc)
      8'h1C: letter_index = 5'd1;   8'h32: letter_index = 5'd2;
      8'h21: letter_index = 5'd3;   8'h23: letter_index = 5'd4;
      8'h24: letter_index = 5'd5;   8'h2B: letter_index = 5'd6;
      8'h34: letter_index = 5'd7;   8'h33: letter_index = 5'd8;
      8'h43: letter_index = 5'd9;   8'h3B: letter_index = 5'd10;
      8'h42: letter_index = 5'd11;  8'h4B: letter_index = 5'd12;
      8'h3A: letter_index = 5'd13;  8'h31: letter_index = 5'd14;
      8'h44: letter_index = 5'd15;  8'h4D: letter_index = 5'd16;
      8'h15: letter_index = 5'd17;  8'h2D: letter_index = 5'd18;
      8'h1B: letter_index = 5'd19;  8'h2C: letter_index = 5'd20;
      8'h3C: letter_index = 5'd21;  8'h2A: letter_index = 5'd22;
      8'h1D: letter_index = 5'd23;  8'h22: letter_index = 5'd24;
      8'h35: letter_index = 5'd25;  8'h1A: letter_index = 5'd26;
      default: letter_index = 5'd0;
    endcase
  endfunction

  // Character code for a plain make code; code_none when the key is unmapped.
  function automatic logic [5:0] map_char(input logic [7:0] sc, input logic shift);
    logic [4:0] idx;
    idx = letter_index(sc);
    if (idx != 5'd0) begin
      map_char = shift ? ({1'b0, idx} + 6'd26) : {1'b0, idx};
    end else begin
      case (sc)
        SC_4:      map_char = shift ? code_dollar : code_none;
        SC_9:      map_char = shift ? code_lparen : code_none;
        SC_0:      map_char = shift ? code_rparen : code_none;
        SC_EQUAL:  map_char = code_equal;
        SC_GRAVE:  map_char = code_starter;
        SC_BSLASH: map_char = code_lambda;
        SC_SPACE:  map_char = code_space;
        SC_DOT:    map_char = code_dot;
        SC_ESC:    map_char = code_end;
        default:   map_char = code_none;
      endcase
    end
  endfunction

endpackage

// File: rtl/kbd_view_encoder_if.sv
// Signal bundle between the board PS/2 pins, the encoder and the text view.
//   master (encoder side): takes ps2_clk/ps2_data/busy_in, drives data/cmd/frame_err
//   slave  (board/view side): the mirror image
// Handshake: there is no ready; data/cmd are fire-and-forget pulses held for a
// fixed number of cycles, frame_err is a single-cycle strobe.
// dec_state / rx_state expose the two internal FSMs for observation.
interface kbd_view_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy_in;
  logic [5:0] data;
  logic [7:0] cmd;
  logic       frame_err;
  logic [1:0] dec_state;
  logic [1:0] rx_state;

  modport master (
    input  ps2_clk, ps2_data, busy_in,
    output data, cmd, frame_err, dec_state, rx_state
  );

  modport slave (
    output ps2_clk, ps2_data, busy_in,
    input  data, cmd, frame_err, dec_state, rx_state
  );
endinterface

// File: rtl/kbd_view_encoder_rx.sv
// PS/2 frame receiver.
//   clk_i, rst_ni          : system clock, async active-low reset
//   ps2_clk_i, ps2_data_i  : raw PS/2 pins (asynchronous)
//   byte_o, byte_valid_o   : received byte, valid for one cycle
//   frame_err_o            : one-cycle strobe on parity/stop/timeout error
//   state_o                : receiver FSM state
module ps2_rx
  import view_codes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic [1:0] state_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  rx_state_e              state_q, state_d;
  logic [7:0]             shreg_q, shreg_d, byte_q, byte_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   par_q, par_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Synchronizers reset to the idle-high line level so no false edge.
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      shreg_q     <= '0;
      byte_q      <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    to_d    = '0;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          // A high start bit is noise; stay idle.
          if (!data_s) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end
        end
        RX_DATA: begin
          shreg_d = {data_s, shreg_q[7:1]};  // LSB arrives first
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = data_s;
          state_d = RX_STOP;
        end
        default: begin
          if (data_s && (^{shreg_q, par_q})) begin
            valid_d = 1'b1;
            byte_d  = shreg_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      endcase
    end else if (state_q != RX_IDLE) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = RX_IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;
  assign state_o      = state_q;
endmodule

// File: rtl/kbd_view_encoder.sv
// PS/2 keyboard (scan set 2) to VGA text-view encoder.
//   clk_50mhz : 50 MHz data clock
//   reset     : asynchronous, active-low
//   bus       : master modport - PS/2 pins and busy_in in; data[5:0] char
//               pulse, cmd[7:0] command pulses (cmd[0] = busy_in), frame_err out
// Decodes make/break/extended prefixes, tracks shift and stretches each
// resulting action into a PULSE_CYCLES-wide pulse on data or one cmd bit.
module kbd_view_encoder
  import view_codes_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input logic               clk_50mhz,
  input logic               reset,
  kbd_view_encoder_if.master bus
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (clk_50mhz),
    .rst_ni      (reset),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (bus.frame_err),
    .state_o     (bus.rx_state)
  );

  dec_state_e    dec_q, dec_d;
  logic          shift_q, shift_d;
  logic [5:0]    data_q, data_d, act_data, ch;
  logic [4:1]    cmd_q, cmd_d, act_cmd;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          fire;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      dec_q   <= DEC_IDLE;
      shift_q <= 1'b0;
      data_q  <= code_null;
      cmd_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      dec_q   <= dec_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    dec_d    = dec_q;
    shift_d  = shift_q;
    act_data = code_null;
    act_cmd  = '0;
    ch       = map_char(rx_byte, shift_q);
    if (rx_valid) begin
      case (dec_q)
        DEC_IDLE: begin
          if (rx_byte == SC_E0)                               dec_d = DEC_EXT;
          else if (rx_byte == SC_F0)                          dec_d = DEC_BRK;
          else if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) shift_d = 1'b1;
          else if (rx_byte == SC_BKSP)                        act_cmd[CMD_BKSP] = 1'b1;
          else if (rx_byte == SC_ENTER)                       act_cmd[CMD_BREAK] = 1'b1;
          else if (ch != code_none)                           act_data = ch;
        end
        DEC_EXT: begin
          if (rx_byte == SC_F0) begin
            dec_d = DEC_EXT_BRK;
          end else begin
            if (rx_byte == SC_UP || rx_byte == SC_PGUP)      act_cmd[CMD_PGUP] = 1'b1;
            else if (rx_byte == SC_DOWN || rx_byte == SC_PGDN) act_cmd[CMD_PGDN] = 1'b1;
            dec_d = DEC_IDLE;
          end
        end
        default: begin
          // Break of any key: only shift releases have an effect.
          if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) shift_d = 1'b0;
          dec_d = DEC_IDLE;
        end
      endcase
    end
  end

  // Busy drops the action but not the decoder/shift bookkeeping above.
  assign fire = rx_valid && !bus.busy_in && (act_data != code_null || act_cmd != '0);

  // Pulse stretcher: a new action always reloads, otherwise count down then clear.
  always_comb begin
    data_d = data_q;
    cmd_d  = cmd_q;
    pcnt_d = pcnt_q;
    if (fire) begin
      data_d = act_data;
      cmd_d  = act_cmd;
      pcnt_d = PW'(PULSE_CYCLES - 1);
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - 1'b1;
    end else begin
      data_d = code_null;
      cmd_d  = '0;
    end
  end

  assign bus.data      = data_q;
  assign bus.cmd       = {3'b000, cmd_q, bus.busy_in};
  assign bus.dec_state = dec_q;
endmodule

// File: tb/tb_kbd_view_encoder.sv
module tb_kbd_view_encoder;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   err_cnt;
  int   run_len;
  logic [9:0]  run_val;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  typedef struct {
    logic [7:0]  sc;
    logic [13:0] ev;   // {len, cmd[4:1], data}; 0 = no pulse expected
  } row_t;
  row_t rows[$];

  kbd_view_encoder_if bus();

  kbd_view_encoder #(
    .PULSE_CYCLES(2), .TIMEOUT_CYCLES(5000), .SYNC_STAGES(2)
  ) dut (
    .clk_50mhz(clk),
    .reset    (reset),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- pulse monitor ----------------
  always @(negedge clk) begin
    logic [9:0] cur;
    cur = {bus.cmd[4:1], bus.data};
    if (reset && bus.frame_err) err_cnt++;
    if (run_len > 0 && cur == run_val) begin
      run_len++;
    end else begin
      if (run_len > 0) obs_q.push_back({4'(run_len), run_val});
      run_val = cur;
      run_len = (cur != 10'd0) ? 1 : 0;
    end
  end

  function automatic logic [13:0] dev(input logic [5:0] d);
    dev = {4'd2, 4'b0000, d};
  endfunction
  function automatic logic [13:0] cev(input logic [3:0] c);
    cev = {4'd2, c, 6'd0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (5) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    bus.ps2_data = 1'b1;
    repeat (15) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, ~(^b), 1'b1, 11);
  endtask

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_sb(input string name, input int exp_err);
    logic [13:0] e, o;
    check_value({name, " pulse_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_value({name, " pulse{len,cmd,data}"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
    check_value({name, " frame_err_count"}, 32'(err_cnt), 32'(exp_err));
    err_cnt = 0;
  endtask

  task automatic add_row(input logic [7:0] sc, input logic [13:0] ev);
    row_t r;
    r.sc = sc;
    r.ev = ev;
    rows.push_back(r);
  endtask

  // ---------------- test ----------------
  initial begin
    n_cmp = 0; n_fail = 0; err_cnt = 0; run_len = 0; run_val = '0;
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.busy_in = 1'b1;
    reset = 1'b0;

    // Reset state (busy_in high to see cmd[0] track it during reset)
    repeat (3) @(posedge clk);
    #1;
    check_value("reset data", 32'(bus.data), 32'd0);
    check_value("reset cmd(busy=1)", 32'(bus.cmd), 32'h01);
    check_value("reset frame_err", 32'(bus.frame_err), 32'd0);
    check_value("reset dec_state", 32'(bus.dec_state), 32'd0);
    bus.busy_in = 1'b0;
    #1;
    check_value("reset cmd(busy=0)", 32'(bus.cmd), 32'h00);
    @(posedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    obs_q.delete(); err_cnt = 0;

    // Table of single frames with their expected pulse
    add_row(8'h1C, dev(6'd1));
    add_row(8'h12, 14'd0);  add_row(8'h1C, dev(6'd27));
    add_row(8'hF0, 14'd0);  add_row(8'h1C, 14'd0);
    add_row(8'hF0, 14'd0);  add_row(8'h12, 14'd0);
    add_row(8'h1C, dev(6'd1));
    add_row(8'hE0, 14'd0);  add_row(8'h75, cev(4'b0001));
    add_row(8'hE0, 14'd0);  add_row(8'hF0, 14'd0);  add_row(8'h75, 14'd0);
    add_row(8'h66, cev(4'b0100));
    add_row(8'h5A, cev(4'b1000));
    add_row(8'h29, dev(6'd59)); add_row(8'h49, dev(6'd60));
    add_row(8'h55, dev(6'd56)); add_row(8'h0E, dev(6'd57));
    add_row(8'h5D, dev(6'd58)); add_row(8'h76, dev(6'd61));
    add_row(8'h1A, dev(6'd26));
    add_row(8'h59, 14'd0);
    add_row(8'h25, dev(6'd53)); add_row(8'h46, dev(6'd54));
    add_row(8'h45, dev(6'd55)); add_row(8'h1A, dev(6'd52));
    add_row(8'hF0, 14'd0);  add_row(8'h59, 14'd0);
    add_row(8'h25, 14'd0);  add_row(8'h16, 14'd0);
    add_row(8'hE0, 14'd0);  add_row(8'h7D, cev(4'b0001));
    add_row(8'hE0, 14'd0);  add_row(8'h7A, cev(4'b0010));
    add_row(8'hE0, 14'd0);  add_row(8'h72, cev(4'b0010));
    add_row(8'h1C, dev(6'd1)); add_row(8'h1C, dev(6'd1));

    foreach (rows[i]) begin
      if (rows[i].ev != 14'd0) exp_q.push_back(rows[i].ev);
      send_byte(rows[i].sc);
      check_sb($sformatf("row%0d sc=%02h", i, rows[i].sc), 0);
    end

    // Bad parity, then bad stop bit, then a good frame
    send_raw(8'h1C, 1'b1, 1'b1, 11);
    check_sb("bad_parity", 1);
    send_raw(8'h1C, 1'b0, 1'b0, 11);
    check_sb("bad_stop", 1);
    exp_q.push_back(dev(6'd26));
    send_byte(8'h1A);
    check_sb("after_errors 1A", 0);

    // Partial frame then idle past the timeout
    send_raw(8'h1C, 1'b0, 1'b1, 5);
    repeat (6000) @(posedge clk);
    check_sb("timeout", 1);
    exp_q.push_back(dev(6'd59));
    send_byte(8'h29);
    check_sb("after_timeout 29", 0);

    // Busy: cmd[0] follows combinationally, action discarded
    @(negedge clk);
    bus.busy_in = 1'b1;
    #1;
    check_value("busy cmd[0]", 32'(bus.cmd), 32'h01);
    send_byte(8'h1C);
    check_sb("busy 1C", 0);
    @(negedge clk);
    bus.busy_in = 1'b0;
    #1;
    check_value("unbusy cmd", 32'(bus.cmd), 32'h00);

    // Reset in the middle of a frame, then a fresh frame
    send_raw(8'h49, 1'b0, 1'b1, 5);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_value("midframe reset rx_state", 32'(bus.rx_state), 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    check_sb("midframe_reset", 0);
    exp_q.push_back(dev(6'd60));
    send_byte(8'h49);
    check_sb("after_reset 49", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_view_encoder.md
Name: kbd_view_encoder

Overview:
- Producer end of the text-view command/data interface: turns a PS/2 keyboard (scan-code set 2) into the 6-bit character codes and command bits consumed by the VGA text view.
- Sits between the board PS/2 pins and the view block's `cmd[7:0]` / `data[5:0]` inputs.
- Runs on the 50 MHz data clock.

Parameters:
- PULSE_CYCLES, 2: width in clk_50mhz cycles of every data/command pulse. 2 guarantees exactly one sample by a consumer that acts only on alternate 50 MHz edges.
- TIMEOUT_CYCLES, 5000: idle cycles mid-frame (100 us) after which a partial PS/2 frame is discarded.
- SYNC_STAGES, 2: synchronizer depth for ps2_clk and ps2_data.

Ports:
- clk_50mhz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin.
- ps2_data  in  1  raw PS/2 data pin.
- busy_in  in  1  controller busy flag, forwarded to cmd[0].
- data  out  6  character code pulse; 0 = nothing.
- cmd  out  8  [0] busy, [1] pg_up, [2] pg_down, [3] backspace, [4] breakline, [7:5] always 0.
- frame_err  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

Behaviour:
- Reset (reset low, async): all of the following clear, and all outputs go to 0 except cmd[0] (comb = busy_in):
  - receiver state, decoder state, shift flag;
  - data = 0; cmd[4:1] = 0; frame_err = 0.
  - Reset mid-frame drops the partial frame.
- Receiver (sub-module):
  - Synchronize ps2_clk and ps2_data; act on each falling edge of synchronized ps2_clk.
  - Frame = start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
  - A start bit of 1 is ignored (stay idle).
  - Byte is valid only if parity is odd and stop = 1; on valid, pulse byte_valid for 1 cycle with byte.
  - Otherwise pulse frame_err and discard the byte.
  - Timeout counter resets on each falling edge. Reaching TIMEOUT_CYCLES while not idle → frame_err, return to idle.
- Decoder FSM, states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0):
  - IDLE: E0 → EXT; F0 → BRK; other byte = make code → action, stay IDLE.
  - EXT: F0 → EXT_BRK; other byte = extended make → action, return to IDLE.
  - BRK and EXT_BRK: next byte is a release → return to IDLE. Releasing 12 or 59 clears shift; all other releases are ignored.
  - Make 12 or 59 sets shift.
- Key mapping (plain make codes):
  - letters a–z → 1–26; with shift → 27–52 (a = 1C → 1, z = 1A → 26);
  - shift+25 ('$') → 53; shift+46 '(' → 54; shift+45 ')' → 55;
  - 55 '=' → 56; 0E '`' → 57 (starter); 5D '\' → 58 (lambda); 29 space → 59; 49 '.' → 60; 76 Esc → 61 (end);
  - 66 → backspace; 5A → breakline.
- Key mapping (extended makes): E0 75 up → pg_up; E0 72 down → pg_down; E0 7D → pg_up; E0 7A → pg_down.
- Unmapped codes are ignored; typematic repeats act like fresh makes.
- Output pulses:
  - An action drives data or the single cmd bit for exactly PULSE_CYCLES cycles, starting the cycle after byte_valid. Latency is 1 cycle from byte_valid and 2 cycles from the registered stop-bit edge.
  - data and cmd[4:1] are never active simultaneously.
  - A new action arriving while a pulse is active is impossible at PS/2 rates; the new action restarts the pulse.
- Busy: while busy_in = 1, character/command actions are discarded. Shift tracking and the FSM continue.

Decomposition:
- Package view_codes_pkg holds:
  - code constants shared with the view (code_null … code_end, code_none);
  - cmd bit indices (CMD_BUSY = 0 … CMD_BREAK = 4);
  - scan-code constants (SC_E0, SC_F0, SC_LSHIFT, SC_RSHIFT, …).
- Sub-module ps2_rx: synchronizer, bit shifter, parity/stop check, timeout. Outputs byte, byte_valid and frame_err.
- The decoder FSM, mapping and pulse stretcher stay in the top module.

Test Plan:
- Frame 1C (odd parity bit 0) → data = 1 for exactly 2 cycles; cmd[4:1] = 0; frame_err = 0.
- Frames 12, 1C, F0 1C, F0 12, 1C → data = 27 then data = 1; the release bytes produce no pulse.
- Frames E0 75 then E0 F0 75 → cmd[1] high 2 cycles once; frames 66 → cmd[3] pulse; 5A → cmd[4] pulse.
- Frame 1C with wrong parity, or stop = 0 → frame_err strobe and no data. Following good frame 1A → data = 26.
- 5 bits of a frame, then 6000 idle cycles → frame_err. Next full frame 29 → data = 59.
- busy_in = 1: cmd[0] follows it combinationally and frame 1C gives no pulse. reset low mid-frame, then a fresh frame 49 → data = 60.
